// File: rtl/color_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// chronos package: task word layout shared by the colour dispatcher and the
// worker cores it feeds.
//   TQ_WIDTH      - width of one task word on the task stream and core bus
//   N_COLOR_CORES - default number of colour worker cores
//   task_t        - packed task word {args, ttype, object, ts}
// -----------------------------------------------------------------------------
package chronos;

    localparam int TQ_WIDTH      = 128;
    localparam int N_COLOR_CORES = 4;

    typedef struct packed {
        logic [63:0] args;
        logic [3:0]  ttype;
        logic [27:0] object;
        logic [31:0] ts;
    } task_t;

endpackage

// File: rtl/color_dispatch_if.sv
// -----------------------------------------------------------------------------
// color_dispatch_if: task stream in, task broadcast and per-core start/ready/
// done strobes out. N_CORES must match the dispatcher it is bound to.
//   slave  - dispatcher view (consumes the stream, drives the cores)
//   master - environment view (produces the stream, models the cores)
// -----------------------------------------------------------------------------
interface color_dispatch_if #(
    parameter int N_CORES = chronos::N_COLOR_CORES
) ();

    logic [chronos::TQ_WIDTH-1:0] task_in_V_TDATA;
    logic                         task_in_V_TVALID;
    logic                         task_in_V_TREADY;
    logic [chronos::TQ_WIDTH-1:0] core_task;
    logic [N_CORES-1:0]           core_ap_start;
    logic [N_CORES-1:0]           core_ap_ready;
    logic [N_CORES-1:0]           core_ap_done;

    modport slave (
        input  task_in_V_TDATA, task_in_V_TVALID,
        output task_in_V_TREADY,
        output core_task, core_ap_start,
        input  core_ap_ready, core_ap_done
    );

    modport master (
        output task_in_V_TDATA, task_in_V_TVALID,
        input  task_in_V_TREADY,
        input  core_task, core_ap_start,
        output core_ap_ready, core_ap_done
    );

endinterface

// File: rtl/color_dispatch_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick.
//   req[N] - request vector
//   ptr    - highest-priority index this cycle
//   gnt[N] - one-hot grant: first requester at or after ptr, wrapping
//   any    - at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    int w_best;
    int w_sel;

    // Pick the requester with the smallest wrapped distance from ptr.
    always_comb begin
        w_best = N;
        w_sel  = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (((i + N - int'(ptr)) % N) < w_best)) begin
                w_best = (i + N - int'(ptr)) % N;
                w_sel  = i;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = req[i] && (w_sel == i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/color_dispatch.sv
// -----------------------------------------------------------------------------
// color_dispatch: single-entry holding register that hands tasks from the
// input stream to N_CORES colour workers, one core per task, round-robin.
//   ap_clk, ap_rst_n  - clock, asynchronous active-low reset
//   bus (slave)       - task stream in, task broadcast + start/ready/done
//   drain             - stop accepting new tasks (held task still dispatches)
//   all_idle          - nothing held and no core busy
//   n_dispatched      - tasks handed to cores (wraps)
//   n_completed       - valid done strobes seen (wraps)
// -----------------------------------------------------------------------------
module color_dispatch
    import chronos::*;
#(
    parameter int N_CORES = N_COLOR_CORES
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    color_dispatch_if.slave bus,
    input  logic            drain,
    output logic            all_idle,
    output logic [31:0]     n_dispatched,
    output logic [31:0]     n_completed
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    task_t               r_held_task;
    logic [N_CORES-1:0]  r_busy;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [31:0]         r_n_disp;
    logic [31:0]         r_n_comp;

    logic [N_CORES-1:0]  w_elig;
    logic [N_CORES-1:0]  w_req;
    logic [N_CORES-1:0]  w_gnt;
    logic [N_CORES-1:0]  w_done_vld;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [PTR_W-1:0]    w_rr_nxt;
    logic                w_fire;
    logic                w_tready;
    logic                w_accept;

    // Only a held task may request a core; an idle core is one that is not
    // tracking an outstanding task and reports ready.
    assign w_elig = ~r_busy & bus.core_ap_ready;
    assign w_req  = (r_state == S_HELD) ? w_elig : '0;

    rr_arbiter #(
        .N  (N_CORES),
        .PW (PTR_W)
    ) u_rr (
        .req (w_req),
        .ptr (r_rr_ptr),
        .gnt (w_gnt),
        .any (w_fire)
    );

    // The slot frees up in the same cycle it dispatches, so a new task can be
    // taken alongside a dispatch. Reset is folded in so TREADY is low while
    // ap_rst_n is asserted.
    assign w_tready   = ap_rst_n & ~drain & ((r_state == S_EMPTY) | w_fire);
    assign w_accept   = bus.task_in_V_TVALID & w_tready;
    // A done on a core we never started is spurious and ignored.
    assign w_done_vld = bus.core_ap_done & r_busy;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (w_gnt[i]) w_gnt_idx = PTR_W'(i);
        end
    end

    assign w_rr_nxt = (w_gnt_idx == PTR_W'(N_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_EMPTY;
        else           r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept)            w_state_nxt = S_HELD;
            S_HELD:  if (w_fire && !w_accept) w_state_nxt = S_EMPTY;
            default:                          w_state_nxt = S_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.task_in_V_TREADY = w_tready;
        bus.core_ap_start    = w_gnt;
        bus.core_task        = r_held_task;
    end

    assign all_idle     = (r_state == S_EMPTY) && (r_busy == '0);
    assign n_dispatched = r_n_disp;
    assign n_completed  = r_n_comp;

    // ---------------- datapath ----------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_held_task <= '0;
            r_busy      <= '0;
            r_rr_ptr    <= '0;
            r_n_disp    <= '0;
            r_n_comp    <= '0;
        end else begin
            if (w_accept) r_held_task <= task_t'(bus.task_in_V_TDATA);
            // A granted core is never busy, so set and clear never collide.
            r_busy   <= (r_busy & ~w_done_vld) | w_gnt;
            r_n_comp <= r_n_comp + 32'($countones(w_done_vld));
            if (w_fire) begin
                r_rr_ptr <= w_rr_nxt;
                r_n_disp <= r_n_disp + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_color_dispatch.sv
module tb_color_dispatch;
    import chronos::*;

    localparam int N = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        drain;
    logic        all_idle;
    logic [31:0] n_dispatched;
    logic [31:0] n_completed;

    color_dispatch_if #(.N_CORES(N)) bus ();

    color_dispatch #(.N_CORES(N)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .bus          (bus),
        .drain        (drain),
        .all_idle     (all_idle),
        .n_dispatched (n_dispatched),
        .n_completed  (n_completed)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one slot, a busy flag per core, a priority pointer.
    logic                m_held;
    logic [TQ_WIDTH-1:0] m_task;
    logic [N-1:0]        m_busy;
    int                  m_rr;
    logic [31:0]         m_nd;
    logic [31:0]         m_nc;
    logic [N-1:0]        e_start;
    logic                e_ready;
    logic                e_idle;
    int                  e_g;

    task automatic model_reset();
        m_held = 1'b0; m_task = '0; m_busy = '0; m_rr = 0; m_nd = '0; m_nc = '0;
    endtask

    task automatic model_eval();
        e_g = -1;
        e_start = '0;
        if (m_held) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (e_g < 0 && !m_busy[c] && bus.core_ap_ready[c]) e_g = c;
            end
        end
        if (e_g >= 0) e_start[e_g] = 1'b1;
        e_ready = ap_rst_n && !drain && (!m_held || e_g >= 0);
        e_idle  = !m_held && (m_busy == '0);
    endtask

    task automatic model_commit();
        logic [N-1:0] ob;
        ob = m_busy;
        for (int i = 0; i < N; i++) begin
            if (bus.core_ap_done[i] && ob[i]) begin
                m_busy[i] = 1'b0;
                m_nc = m_nc + 32'd1;
            end
        end
        if (e_g >= 0) begin
            m_busy[e_g] = 1'b1;
            m_nd = m_nd + 32'd1;
            m_rr = (e_g + 1) % N;
        end
        if (bus.task_in_V_TVALID && e_ready) begin
            m_held = 1'b1;
            m_task = bus.task_in_V_TDATA;
        end else if (e_g >= 0) begin
            m_held = 1'b0;
        end
    endtask

    function automatic logic [TQ_WIDTH-1:0] rnd_task();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Apply inputs on the falling edge; outputs are then sampled 1ns later.
    task automatic drive(input logic v, input logic [TQ_WIDTH-1:0] d,
                         input logic [N-1:0] rdy, input logic [N-1:0] dn, input logic dr);
        @(negedge ap_clk);
        bus.task_in_V_TVALID = v;
        bus.task_in_V_TDATA  = d;
        bus.core_ap_ready    = rdy;
        bus.core_ap_done     = dn;
        drain                = dr;
        #1 model_eval();
    endtask

    task automatic tick();
        @(posedge ap_clk);
        model_commit();
    endtask

    task automatic apply_reset();
        @(negedge ap_clk);
        bus.task_in_V_TVALID = 1'b0;
        bus.core_ap_done     = '0;
        drain                = 1'b0;
        ap_rst_n             = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        bus.task_in_V_TVALID = 1'b0;
        bus.task_in_V_TDATA  = '0;
        bus.core_ap_ready    = '1;
        bus.core_ap_done     = '0;
        drain                = 1'b0;
        #3;
        n_cmp++; if (bus.task_in_V_TREADY !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b want 0", bus.task_in_V_TREADY); end
        n_cmp++; if (bus.core_ap_start !== 4'b0000) begin n_bad++; $display("FAIL rst_start: got %b want 0000", bus.core_ap_start); end
        n_cmp++; if (all_idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b want 1", all_idle); end
        n_cmp++; if (n_dispatched !== 32'd0 || n_completed !== 32'd0) begin n_bad++; $display("FAIL rst_counters: got %0d/%0d want 0/0", n_dispatched, n_completed); end
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_reset();
        drive(1'b0, '0, '1, '0, 1'b0);
        n_cmp++; if (bus.task_in_V_TREADY !== 1'b1) begin n_bad++; $display("FAIL rst_release_tready: got %b want 1", bus.task_in_V_TREADY); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [TQ_WIDTH-1:0] t [5];
        logic [N-1:0] want;
        apply_reset();
        for (int i = 0; i < 5; i++) t[i] = rnd_task();
        for (int c = 0; c < 6; c++) begin
            drive(c < 5, t[c % 5], '1, '0, 1'b0);
            if (c >= 1 && c <= 4) begin
                want = 4'b0001 << (c - 1);
                n_cmp++; if (bus.core_ap_start !== want) begin n_bad++; $display("FAIL b2b_start c%0d: got %b want %b", c, bus.core_ap_start, want); end
                n_cmp++; if (bus.core_task !== t[c-1]) begin n_bad++; $display("FAIL b2b_task c%0d: got %h want %h", c, bus.core_task, t[c-1]); end
            end
            if (c == 5) begin
                n_cmp++; if (bus.core_ap_start !== 4'b0000 || bus.task_in_V_TREADY !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got start %b tready %b want 0000 0", bus.core_ap_start, bus.task_in_V_TREADY); end
                n_cmp++; if (bus.core_task !== t[4]) begin n_bad++; $display("FAIL b2b_held_E: got %h want %h", bus.core_task, t[4]); end
            end
            tick();
        end
        drive(1'b0, '0, '1, '0, 1'b0);
        n_cmp++; if (n_dispatched !== 32'd4) begin n_bad++; $display("FAIL b2b_ndisp: got %0d want 4", n_dispatched); end
        tick();
    endtask

    task automatic test_skip_not_ready();
        apply_reset();
        drive(1'b1, rnd_task(), '1, '0, 1'b0); tick();
        drive(1'b0, '0, '1, '0, 1'b0); tick();
        drive(1'b0, '0, '1, 4'b0001, 1'b0); tick();
        drive(1'b1, rnd_task(), 4'b1101, '0, 1'b0); tick();
        drive(1'b0, '0, 4'b1101, '0, 1'b0);
        n_cmp++; if (bus.core_ap_start !== 4'b0100) begin n_bad++; $display("FAIL skip_core1: got %b want 0100", bus.core_ap_start); end
        tick();
        drive(1'b1, rnd_task(), '1, '0, 1'b0); tick();
        drive(1'b0, '0, '1, '0, 1'b0);
        n_cmp++; if (bus.core_ap_start !== 4'b1000) begin n_bad++; $display("FAIL skip_rr3: got %b want 1000", bus.core_ap_start); end
        tick();
    endtask

    task automatic test_done_with_dispatch();
        apply_reset();
        drive(1'b1, rnd_task(), '1, '0, 1'b0); tick();
        drive(1'b1, rnd_task(), '1, '0, 1'b0); tick();
        drive(1'b1, rnd_task(), '1, '0, 1'b0); tick();
        drive(1'b0, '0, '1, '0, 1'b0); tick();
        drive(1'b0, '0, '1, 4'b0110, 1'b0); tick();
        drive(1'b1, rnd_task(), '1, '0, 1'b0);
        n_cmp++; if (n_completed !== 32'd2) begin n_bad++; $display("FAIL dd_popcount: got %0d want 2", n_completed); end
        tick();
        drive(1'b0, '0, '1, 4'b0001, 1'b0);
        n_cmp++; if (bus.core_ap_start !== 4'b1000) begin n_bad++; $display("FAIL dd_start3: got %b want 1000", bus.core_ap_start); end
        tick();
        drive(1'b1, rnd_task(), '1, '0, 1'b0);
        n_cmp++; if (n_completed !== 32'd3 || n_dispatched !== 32'd4) begin n_bad++; $display("FAIL dd_counters: got %0d/%0d want 4/3", n_dispatched, n_completed); end
        n_cmp++; if (all_idle !== 1'b0) begin n_bad++; $display("FAIL dd_idle: got %b want 0", all_idle); end
        tick();
        drive(1'b0, '0, '1, '0, 1'b0);
        n_cmp++; if (bus.core_ap_start !== 4'b0001) begin n_bad++; $display("FAIL dd_core0_free: got %b want 0001", bus.core_ap_start); end
        tick();
        drive(1'b1, rnd_task(), '1, '0, 1'b0); tick();
        drive(1'b0, '0, 4'b1000, '0, 1'b0);
        n_cmp++; if (bus.core_ap_start !== 4'b0000) begin n_bad++; $display("FAIL dd_core3_busy: got %b want 0000", bus.core_ap_start); end
        tick();
    endtask

    task automatic test_drain();
        logic [TQ_WIDTH-1:0] t1;
        t1 = rnd_task();
        apply_reset();
        drive(1'b1, rnd_task(), '0, '0, 1'b0); tick();
        drive(1'b1, t1, '0, '0, 1'b1);
        n_cmp++; if (bus.task_in_V_TREADY !== 1'b0) begin n_bad++; $display("FAIL drain_tready_held: got %b want 0", bus.task_in_V_TREADY); end
        tick();
        drive(1'b1, t1, '1, '0, 1'b1);
        n_cmp++; if (bus.core_ap_start !== 4'b0001) begin n_bad++; $display("FAIL drain_dispatch: got %b want 0001", bus.core_ap_start); end
        n_cmp++; if (bus.task_in_V_TREADY !== 1'b0) begin n_bad++; $display("FAIL drain_tready_fire: got %b want 0", bus.task_in_V_TREADY); end
        tick();
        drive(1'b1, t1, '1, '0, 1'b1);
        n_cmp++; if (bus.task_in_V_TREADY !== 1'b0 || all_idle !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got tready %b idle %b want 0 0", bus.task_in_V_TREADY, all_idle); end
        tick();
        drive(1'b0, '0, '1, 4'b0001, 1'b1); tick();
        drive(1'b0, '0, '1, '0, 1'b1);
        n_cmp++; if (all_idle !== 1'b1 || n_completed !== 32'd1) begin n_bad++; $display("FAIL drain_idle: got idle %b ncomp %0d want 1 1", all_idle, n_completed); end
        tick();
    endtask

    task automatic test_spurious_done();
        drive(1'b0, '0, '1, 4'b0100, 1'b0); tick();
        drive(1'b0, '0, '1, '0, 1'b0);
        n_cmp++; if (n_completed !== m_nc || n_dispatched !== m_nd) begin n_bad++; $display("FAIL spurious_cnt: got %0d/%0d want %0d/%0d", n_dispatched, n_completed, m_nd, m_nc); end
        n_cmp++; if (all_idle !== 1'b1) begin n_bad++; $display("FAIL spurious_idle: got %b want 1", all_idle); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, rnd_task(), '1, '0, 1'b0); tick();
        drive(1'b1, rnd_task(), '1, '0, 1'b0);
        n_cmp++; if (bus.core_ap_start !== e_start || e_start == '0) begin n_bad++; $display("FAIL mid_pre_start: got %b want %b", bus.core_ap_start, e_start); end
        #1 ap_rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.core_ap_start !== 4'b0000 || bus.task_in_V_TREADY !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out: got start %b tready %b want 0000 0", bus.core_ap_start, bus.task_in_V_TREADY); end
        n_cmp++; if (all_idle !== 1'b1 || n_dispatched !== 32'd0 || n_completed !== 32'd0) begin n_bad++; $display("FAIL mid_rst_state: got idle %b cnt %0d/%0d want 1 0/0", all_idle, n_dispatched, n_completed); end
        model_reset();
        drive(1'b0, '0, '1, '0, 1'b0); tick();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        drive(1'b0, '0, '1, '0, 1'b0);
        n_cmp++; if (bus.task_in_V_TREADY !== 1'b1 || all_idle !== 1'b1) begin n_bad++; $display("FAIL mid_release: got tready %b idle %b want 1 1", bus.task_in_V_TREADY, all_idle); end
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, rnd_task(), N'($urandom), N'($urandom & $urandom), ($urandom % 8) == 0);
            n_cmp++; if (bus.task_in_V_TREADY !== e_ready) begin n_bad++; $display("FAIL rnd_tready c%0d: got %b want %b", c, bus.task_in_V_TREADY, e_ready); end
            n_cmp++; if (bus.core_ap_start !== e_start) begin n_bad++; $display("FAIL rnd_start c%0d: got %b want %b", c, bus.core_ap_start, e_start); end
            n_cmp++; if (all_idle !== e_idle) begin n_bad++; $display("FAIL rnd_idle c%0d: got %b want %b", c, all_idle, e_idle); end
            n_cmp++; if (n_dispatched !== m_nd || n_completed !== m_nc) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, n_dispatched, n_completed, m_nd, m_nc); end
            if (m_held) begin
                n_cmp++; if (bus.core_task !== m_task) begin n_bad++; $display("FAIL rnd_task c%0d: got %h want %h", c, bus.core_task, m_task); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skip_not_ready();
        test_done_with_dispatch();
        test_drain();
        test_spurious_done();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
